// File: rtl/tc_psum_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tc_psum_pkg                                                  |
// | Description : Shared definitions for the partial-sum accumulation buffer:  |
// |               FSM state encoding, default widths and the saturating adder  |
// |               used when TC_PSUM_ACC_SAT_EN is defined.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package tc_psum_pkg;

    // FSM state encoding
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_accum = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    // Default geometry and widths
    localparam int c_def_m       = 16;
    localparam int c_def_n       = 16;
    localparam int c_def_num_in  = 4;
    localparam int c_def_dw_data = 8;
    localparam int c_def_dw_acc  = 16;
    localparam int c_def_dw_pos  = 4;

    // Adds two sign-extended operands at full precision and clamps the result
    // to the signed range of a w-bit accumulator. The caller truncates the
    // return value back to w bits.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 w
    );
        logic signed [63:0] w_sum;
        logic signed [63:0] w_max;
        logic signed [63:0] w_min;
        w_sum = a + b;
        w_max = (64'sd1 <<< (w - 1)) - 64'sd1;
        w_min = -w_max - 64'sd1;
        if (w_sum > w_max) begin
            return w_max;
        end else if (w_sum < w_min) begin
            return w_min;
        end
        return w_sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tc_psum_lane_merge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tc_psum_lane_merge                                           |
// | Description : Combinational lane merge for one accumulator column. For     |
// |               every row it reports whether any enabled lane targets that   |
// |               (row, COL) entry and the merged value: the sign-extended sum |
// |               of all hitting lanes (accumulate) or the lowest-index        |
// |               hitting lane (overwrite).                                    |
// | Ports       : i_lane_en   - per-lane accepted flag                         |
// |               i_row/i_col - per-lane packed row/column indices             |
// |               i_data      - per-lane packed signed values                  |
// |               i_acc_mode  - 1 = sum lanes, 0 = lowest lane wins            |
// |               o_hit       - per-row hit flag for this column               |
// |               o_val       - per-row merged value, DW_SUM bits each         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tc_psum_lane_merge
    import tc_psum_pkg::*;
#(
    parameter int M       = c_def_m,
    parameter int NUM_IN  = c_def_num_in,
    parameter int DW_DATA = c_def_dw_data,
    parameter int DW_POS  = c_def_dw_pos,
    parameter int DW_SUM  = c_def_dw_acc,
    parameter int COL     = 0
) (
    input  logic [NUM_IN-1:0]         i_lane_en,
    input  logic [NUM_IN*DW_POS-1:0]  i_row,
    input  logic [NUM_IN*DW_POS-1:0]  i_col,
    input  logic [NUM_IN*DW_DATA-1:0] i_data,
    input  logic                      i_acc_mode,
    output logic [M-1:0]              o_hit,
    output logic [M*DW_SUM-1:0]       o_val
);

    logic [NUM_IN-1:0] w_col_match;
    logic [DW_SUM-1:0] w_ext [NUM_IN];
    logic [DW_SUM-1:0] w_sum;
    logic [DW_SUM-1:0] w_sel;
    logic              w_found;

    // Matching against in-range row/column numbers only is what drops lanes
    // with row >= M or col >= N: such indices never equal any r or COL here.
    always_comb begin
        for (int l = 0; l < NUM_IN; l++) begin
            w_col_match[l] = i_lane_en[l] &&
                             (i_col[l*DW_POS +: DW_POS] == DW_POS'(COL));
            w_ext[l]       = DW_SUM'($signed(i_data[l*DW_DATA +: DW_DATA]));
        end
    end

    always_comb begin
        o_hit   = '0;
        o_val   = '0;
        w_sum   = '0;
        w_sel   = '0;
        w_found = 1'b0;
        for (int r = 0; r < M; r++) begin
            w_sum   = '0;
            w_sel   = '0;
            w_found = 1'b0;
            for (int l = 0; l < NUM_IN; l++) begin
                if (w_col_match[l] && (i_row[l*DW_POS +: DW_POS] == DW_POS'(r))) begin
                    w_sum = w_sum + w_ext[l];
                    // Lanes are scanned low to high, so the first hit is the
                    // lowest index and later colliding lanes are ignored.
                    if (!w_found) begin
                        w_sel   = w_ext[l];
                        w_found = 1'b1;
                    end
                end
            end
            o_hit[r]                  = w_found;
            o_val[r*DW_SUM +: DW_SUM] = i_acc_mode ? w_sum : w_sel;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tc_psum_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tc_psum_acc                                                  |
// | Description : M x N signed partial-sum accumulation buffer. Takes up to    |
// |               NUM_IN sparse (row, col, value) updates per cycle in         |
// |               accumulate or overwrite mode and drains the tile row by row  |
// |               over a valid/ready stream, zeroing each row as it is taken.  |
// |               Define TC_PSUM_ACC_SAT_EN to saturate accumulate-mode        |
// |               results instead of wrapping.                                 |
// | Ports       : clk, rst (async, active high)                                |
// |               in_valid/in_ready/in_row/in_col/in_data/acc_mode - updates   |
// |               drain_start                      - request a tile drain      |
// |               out_valid/out_ready/out_row/out_data/out_last - row stream   |
// |               busy                             - FSM not idle              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tc_psum_acc
    import tc_psum_pkg::*;
#(
    parameter int M       = c_def_m,
    parameter int N       = c_def_n,
    parameter int NUM_IN  = c_def_num_in,
    parameter int DW_DATA = c_def_dw_data,
    parameter int DW_ACC  = c_def_dw_acc,
    parameter int DW_POS  = c_def_dw_pos
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_IN-1:0]         in_valid,
    output logic                      in_ready,
    input  logic [NUM_IN*DW_POS-1:0]  in_row,
    input  logic [NUM_IN*DW_POS-1:0]  in_col,
    input  logic [NUM_IN*DW_DATA-1:0] in_data,
    input  logic                      acc_mode,
    input  logic                      drain_start,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DW_POS-1:0]         out_row,
    output logic [N*DW_ACC-1:0]       out_data,
    output logic                      out_last,
    output logic                      busy
);

    // With saturation the lane sum is kept wide enough that it cannot wrap
    // before the clamp; without it, wrapping in DW_ACC is the wanted result.
`ifdef TC_PSUM_ACC_SAT_EN
    localparam int c_dw_sum = DW_ACC + $clog2(NUM_IN) + 1;
`else
    localparam int c_dw_sum = DW_ACC;
`endif

    logic [1:0]                  r_state;
    logic [1:0]                  w_state_nxt;
    logic [DW_POS-1:0]           r_out_row;
    logic signed [DW_ACC-1:0]    r_acc  [M][N];
    logic signed [DW_ACC-1:0]    w_next [M][N];
    logic signed [c_dw_sum-1:0]  w_merged;
    logic [M-1:0]                w_hit  [N];
    logic [M*c_dw_sum-1:0]       w_val  [N];
    logic [NUM_IN-1:0]           w_lane_en;
    logic                        w_out_hs;
    logic                        w_at_last;

    assign in_ready  = (r_state != c_st_drain);
    assign w_lane_en = in_valid & {NUM_IN{in_ready}};
    assign out_valid = (r_state == c_st_drain);
    assign w_out_hs  = out_valid && out_ready;
    assign w_at_last = (r_out_row == DW_POS'(M - 1));
    assign out_row   = r_out_row;
    assign out_last  = out_valid && w_at_last;
    assign busy      = (r_state != c_st_idle);

    // ------------------------------------------------------------------------
    // Per-column lane merge
    // ------------------------------------------------------------------------
    for (genvar gv_c = 0; gv_c < N; gv_c++) begin : g_col
        tc_psum_lane_merge #(
            .M       (M),
            .NUM_IN  (NUM_IN),
            .DW_DATA (DW_DATA),
            .DW_POS  (DW_POS),
            .DW_SUM  (c_dw_sum),
            .COL     (gv_c)
        ) u_merge (
            .i_lane_en  (w_lane_en),
            .i_row      (in_row),
            .i_col      (in_col),
            .i_data     (in_data),
            .i_acc_mode (acc_mode),
            .o_hit      (w_hit[gv_c]),
            .o_val      (w_val[gv_c])
        );
    end

    // ------------------------------------------------------------------------
    // Next entry value for every accumulator (used only where hit)
    // ------------------------------------------------------------------------
    always_comb begin
        w_merged = '0;
        for (int r = 0; r < M; r++) begin
            for (int c = 0; c < N; c++) begin
                w_merged = w_val[c][r*c_dw_sum +: c_dw_sum];
                if (acc_mode) begin
`ifdef TC_PSUM_ACC_SAT_EN
                    w_next[r][c] = DW_ACC'(sat_add(64'(r_acc[r][c]), 64'(w_merged), DW_ACC));
`else
                    w_next[r][c] = r_acc[r][c] + w_merged;
`endif
                end else begin
                    // The merged value is already sign-extended, so the low
                    // DW_ACC bits are the sign-extended lane value.
                    w_next[r][c] = w_merged[DW_ACC-1:0];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Accumulator array. Updates only occur outside DRAIN and row clears only
    // inside DRAIN, so the two never compete for an entry.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < M; r++) begin
                for (int c = 0; c < N; c++) begin
                    r_acc[r][c] <= '0;
                end
            end
        end else begin
            for (int r = 0; r < M; r++) begin
                for (int c = 0; c < N; c++) begin
                    if (w_hit[c][r]) begin
                        r_acc[r][c] <= w_next[r][c];
                    end else if (w_out_hs && (r_out_row == DW_POS'(r))) begin
                        r_acc[r][c] <= '0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (drain_start) begin
                    w_state_nxt = c_st_drain;
                end else if (|w_lane_en) begin
                    w_state_nxt = c_st_accum;
                end
            end
            c_st_accum: begin
                if (drain_start) begin
                    w_state_nxt = c_st_drain;
                end
            end
            c_st_drain: begin
                if (w_out_hs && w_at_last) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // Row pointer sits at 0 whenever a drain begins: it wraps back after the
    // last row and reset also clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_row <= '0;
        end else if (w_out_hs) begin
            r_out_row <= w_at_last ? '0 : r_out_row + 1'b1;
        end
    end

    // Row read-out; the tile cannot change during DRAIN so this is stable
    // under backpressure.
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            for (int c = 0; c < N; c++) begin
                out_data[c*DW_ACC +: DW_ACC] = r_acc[r_out_row][c];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tc_psum_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_tc_psum_acc                                               |
// | Description : Directed self-checking bench for tc_psum_acc. A small tile   |
// |               model holds hand-computed expected contents; each drain      |
// |               compares every presented row against it.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_tc_psum_acc;

    localparam int M       = 16;
    localparam int N       = 16;
    localparam int NUM_IN  = 4;
    localparam int DW_DATA = 8;
    localparam int DW_ACC  = 16;
    localparam int DW_POS  = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_IN-1:0]         in_valid;
    logic                      in_ready;
    logic [NUM_IN*DW_POS-1:0]  in_row;
    logic [NUM_IN*DW_POS-1:0]  in_col;
    logic [NUM_IN*DW_DATA-1:0] in_data;
    logic                      acc_mode;
    logic                      drain_start;
    logic                      out_valid;
    logic                      out_ready;
    logic [DW_POS-1:0]         out_row;
    logic [N*DW_ACC-1:0]       out_data;
    logic                      out_last;
    logic                      busy;

    tc_psum_acc #(
        .M       (M),
        .N       (N),
        .NUM_IN  (NUM_IN),
        .DW_DATA (DW_DATA),
        .DW_ACC  (DW_ACC),
        .DW_POS  (DW_POS)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_row      (in_row),
        .in_col      (in_col),
        .in_data     (in_data),
        .acc_mode    (acc_mode),
        .drain_start (drain_start),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row     (out_row),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic signed [DW_ACC-1:0] r_model [M][N];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_lanes();
        in_valid = '0;
        in_row   = '0;
        in_col   = '0;
        in_data  = '0;
    endtask

    task automatic set_lane(input int l, input int row, input int col, input int val);
        in_valid[l]                   = 1'b1;
        in_row[l*DW_POS +: DW_POS]    = DW_POS'(row);
        in_col[l*DW_POS +: DW_POS]    = DW_POS'(col);
        in_data[l*DW_DATA +: DW_DATA] = DW_DATA'(val);
    endtask

    task automatic clear_model();
        for (int r = 0; r < M; r++) begin
            for (int c = 0; c < N; c++) begin
                r_model[r][c] = '0;
            end
        end
    endtask

    function automatic logic [N*DW_ACC-1:0] pack_row(input int r);
        logic [N*DW_ACC-1:0] v;
        for (int c = 0; c < N; c++) begin
            v[c*DW_ACC +: DW_ACC] = r_model[r][c];
        end
        return v;
    endfunction

    // Walks a drain that is already presenting row 0. Row stall_row is held
    // off for two cycles with out_ready low before being accepted.
    task automatic drain_check(input string name, input int stall_row);
        for (int r = 0; r < M; r++) begin
            chk($sformatf("%s_valid_r%0d", name, r), out_valid, 1'b1);
            chk($sformatf("%s_row_r%0d", name, r), out_row, r);
            chk($sformatf("%s_data_r%0d", name, r), out_data, pack_row(r));
            chk($sformatf("%s_last_r%0d", name, r), out_last, (r == M - 1));
            chk($sformatf("%s_inrdy_r%0d", name, r), in_ready, 1'b0);
            if (r == stall_row) begin
                out_ready = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    step();
                    chk($sformatf("%s_stall_row_s%0d", name, s), out_row, r);
                    chk($sformatf("%s_stall_data_s%0d", name, s), out_data, pack_row(r));
                    chk($sformatf("%s_stall_valid_s%0d", name, s), out_valid, 1'b1);
                    chk($sformatf("%s_stall_inrdy_s%0d", name, s), in_ready, 1'b0);
                end
            end
            out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        chk({name, "_end_valid"}, out_valid, 1'b0);
        chk({name, "_end_busy"}, busy, 1'b0);
        chk({name, "_end_inrdy"}, in_ready, 1'b1);
        clear_model();
    endtask

    task automatic start_drain();
        drain_start = 1'b1;
        step();
        drain_start = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        acc_mode    = 1'b1;
        drain_start = 1'b0;
        out_ready   = 1'b0;
        clear_lanes();
        clear_model();
        repeat (3) step();

        // Reset state
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_row", out_row, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_inrdy", in_ready, 1'b1);
        rst = 1'b0;
        step();

        // Accumulate: four-lane collision 1+2+3-1 at (2,3), then mixed targets
        acc_mode = 1'b1;
        set_lane(0, 2, 3, 1);
        set_lane(1, 2, 3, 2);
        set_lane(2, 2, 3, 3);
        set_lane(3, 2, 3, -1);
        step();
        clear_lanes();
        chk("acc_busy", busy, 1'b1);
        chk("acc_inrdy", in_ready, 1'b1);
        r_model[2][3] = 16'sd5;
        set_lane(0, 3, 4, 10);
        set_lane(1, 3, 4, -20);
        set_lane(2, 15, 15, -128);
        set_lane(3, 15, 0, 127);
        step();
        clear_lanes();
        r_model[3][4]   = -16'sd10;
        r_model[15][15] = -16'sd128;
        r_model[15][0]  = 16'sd127;
        start_drain();
        drain_check("acc", -1);

        // Overwrite: lowest colliding lane wins, later write replaces entry
        acc_mode = 1'b0;
        set_lane(1, 0, 0, 7);
        set_lane(2, 0, 0, 9);
        set_lane(3, 5, 6, -3);
        step();
        clear_lanes();
        set_lane(0, 0, 0, -4);
        step();
        clear_lanes();
        r_model[0][0] = 16'shFFFC;
        r_model[5][6] = 16'shFFFD;

        // Backpressure on row 1; an update offered during DRAIN is refused
        start_drain();
        acc_mode = 1'b1;
        set_lane(0, 0, 0, 50);
        drain_check("bp", 1);
        clear_lanes();

        // Same-cycle update and drain_start; second drain must be empty
        acc_mode = 1'b1;
        set_lane(0, 0, 1, 5);
        drain_start = 1'b1;
        step();
        drain_start = 1'b0;
        clear_lanes();
        r_model[0][1] = 16'sd5;
        drain_check("same", -1);
        start_drain();
        drain_check("empty", -1);

        // Overflow: 300 x +127 at (1,1)
        acc_mode = 1'b1;
        set_lane(0, 1, 1, 127);
        repeat (300) step();
        clear_lanes();
`ifdef TC_PSUM_ACC_SAT_EN
        r_model[1][1] = 16'sd32767;
`else
        r_model[1][1] = -16'sd27436;
`endif
        start_drain();
        drain_check("ovf", -1);

        // Asynchronous reset in the middle of a drain at row 5
        set_lane(0, 7, 2, 3);
        step();
        clear_lanes();
        start_drain();
        out_ready = 1'b1;
        repeat (5) step();
        out_ready = 1'b0;
        chk("mid_row5", out_row, 5);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_row", out_row, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_last", out_last, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        step();
        rst = 1'b0;
        step();
        clear_model();
        start_drain();
        drain_check("post_rst", -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tc_psum_acc.md
Name: tc_psum_acc

Overview:
- Multi-lane partial-sum accumulation buffer for the sparse tensor core output stage.
- Holds an M x N tile of signed accumulators. Accepts up to NUM_IN sparse (row, col, value) updates per cycle, in accumulate or overwrite mode.
- Drains the tile row by row over a valid/ready stream, clearing each row as it is read.
- Sits between the PE array psum outputs and the writeback path.

Parameters:
- M, 16, tile rows
- N, 16, tile columns (accumulators per output row)
- NUM_IN, 4, update lanes per cycle
- DW_DATA, 8, signed input value width
- DW_ACC, 16, signed accumulator width (must be at least DW_DATA)
- DW_POS, 4, row/col index width (2^DW_POS >= max(M,N))

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  NUM_IN  per-lane update valid
- in_ready  out  1  updates accepted this cycle (shared by all lanes)
- in_row  in  NUM_IN*DW_POS  per-lane row index
- in_col  in  NUM_IN*DW_POS  per-lane column index
- in_data  in  NUM_IN*DW_DATA  per-lane signed value
- acc_mode  in  1  1 = add to entry, 0 = overwrite entry
- drain_start  in  1  request tile drain
- out_valid  out  1  out_data/out_row valid
- out_ready  in  1  downstream accepts row
- out_row  out  DW_POS  index of the row presented
- out_data  out  N*DW_ACC  row contents; column c at [c*DW_ACC +: DW_ACC]
- out_last  out  1  presented row is M-1
- busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, any state including mid-drain): all accumulators 0, state IDLE, out_valid 0, out_row 0, out_data 0, out_last 0, busy 0.
- FSM states: IDLE, ACCUM, DRAIN.
  - IDLE -> ACCUM on any accepted lane.
  - IDLE or ACCUM -> DRAIN on drain_start.
  - DRAIN -> IDLE after the handshake with out_last=1.
  - drain_start is ignored while in DRAIN.
- in_ready = (state != DRAIN).
- A lane is accepted when its in_valid bit is 1 and in_ready is 1. The update is visible in the array the next cycle.
- Lanes whose row >= M or col >= N are dropped silently.
- Accumulate mode (acc_mode=1):
  - Each entry becomes old + sign-extended sum of all accepted lanes targeting that (row,col) in the same cycle.
  - Lane collisions sum; arithmetic is two's complement in DW_ACC, wrapping on overflow.
- Overwrite mode (acc_mode=0):
  - Entry becomes the sign-extended value of the lowest-index accepted lane targeting it.
  - Higher-index colliding lanes are discarded.
- Same-cycle in_valid and drain_start in IDLE/ACCUM: the updates are accepted and committed, then the block enters DRAIN.
- Drain sequence:
  - One cycle after drain_start is sampled: out_valid=1, out_row=0, out_data=row 0 (including that cycle's committed updates).
  - While out_valid=1 and out_ready=0: out_row, out_data and out_last hold stable.
  - On handshake at row r < M-1: row r is zeroed, and the next cycle presents row r+1 (one row per cycle under continuous ready).
  - On handshake at row M-1: row zeroed, out_valid drops next cycle, state IDLE, in_ready returns to 1.
- out_last = out_valid && (out_row == M-1).
- A full drain takes M handshakes; the tile is all-zero afterwards.

Optional Feature:
- Macro: TC_PSUM_ACC_SAT_EN.
- Defined: accumulate-mode results saturate to [-2^(DW_ACC-1), 2^(DW_ACC-1)-1] after the full same-cycle lane sum is added.
- Not defined: two's-complement wrap.
- Overwrite mode is unaffected either way.

Decomposition:
- Package tc_psum_pkg holds:
  - FSM state encoding (IDLE=0, ACCUM=1, DRAIN=2)
  - default widths
  - sat_add function (used only under TC_PSUM_ACC_SAT_EN)
- One sub-module: tc_psum_lane_merge.
  - Combinational; per (row,col) it produces a hit flag and the merged lane value (sum or lowest-lane select by acc_mode).
  - Instantiated once per column, with a row match inside.

Test Plan:
- Accumulate, lanes 0..3 all hit (2,3) with values 1,2,3,-1 in one cycle, then drain -> row 2 col 3 = 5; all other entries 0; out_last only on out_row 15.
- Overwrite: lane1 writes (0,0)=7 and lane2 writes (0,0)=9 in one cycle, then lane0 writes (0,0)=-4 -> drain row 0 col 0 = 0xFFFC (DW_ACC=16).
- Backpressure: drain with out_ready toggling 1,0,0,1 -> out_row advances only on ready cycles, out_data stable while stalled; in_ready=0 throughout DRAIN.
- Same-cycle in_valid on (0,1)=5 plus drain_start -> first drained row 0 shows col 1 = 5; a second drain immediately after shows all zeros.
- Overflow: accumulate +127 into (1,1) 300 times -> without macro 38100 wraps to -27436; with TC_PSUM_ACC_SAT_EN it reads 32767.
- Reset asserted mid-drain at out_row 5 -> outputs 0 immediately; the next drain returns all zeros; busy=0.
